alarm_rtc_core: RTL and testbench

- Time-of-day and alarm engine that sits directly downstream of the 1 ms interval timer.
- Consumes the timer's one-cycle timeout pulse as `tick_in` and prescales it to seconds.
- Keeps BCD hh:mm:ss and compares against a programmable alarm, with snooze.
- Raises `irq` to the Nios II through a 16-bit Avalon-MM slave port with the same bus timing as the timer.

---
 rtl/alarm_rtc_core.sv | 263 ++++++++++++++++++++++++++
 tb/tb_alarm_rtc_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_rtc_core.sv
// -----------------------------------------------------------------------------
// alarm_rtc_core
//
// Time-of-day and alarm engine fed by the 1 ms interval timer. The timer's
// one-cycle timeout pulse (tick_in) is prescaled to seconds. A BCD hh:mm:ss
// clock is compared against a programmable alarm on every minute rollover.
// A snooze counter can re-arm the alarm after a set number of minutes. Status
// and control live behind a 16-bit Avalon-MM slave with one-cycle read latency.
//
// Parameters
//   TICKS_PER_SEC  tick_in pulses per second (2..65535)
//   SNOOZE_RESET   reset value of the snooze length, minutes
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   address       register select (0..7)
//   chipselect    slave select
//   write_n       active-low write strobe
//   writedata     write data
//   readdata      registered read data, valid one cycle after address
//   tick_in       one-cycle timebase pulse
//   irq           interrupt to the CPU
//   alarm_active  alarm flag, drives the buzzer
//
// Register map (unused bits read 0)
//   0 STATUS    rd {snooze_active, sec_flag, alarm_flag}
//               wr bit0 clear alarm, bit1 clear sec, bit2 snooze
//   1 CONTROL   [3:0] = {irq_sec_en, irq_alarm_en, alarm_en, run}
//   2 TIME_HM   [13:8] hours BCD, [6:0] minutes BCD
//   3 TIME_S    [6:0] seconds BCD
//   4 ALARM_HM  same layout as TIME_HM
//   5 SNOOZE    [5:0] snooze minutes, 0 behaves as 1
// -----------------------------------------------------------------------------
module alarm_rtc_core #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned SNOOZE_RESET  = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic        tick_in,
    output logic        irq,
    output logic        alarm_active
);

    typedef enum logic [2:0] {
        ADDR_STATUS   = 3'd0,
        ADDR_CONTROL  = 3'd1,
        ADDR_TIME_HM  = 3'd2,
        ADDR_TIME_S   = 3'd3,
        ADDR_ALARM_HM = 3'd4,
        ADDR_SNOOZE   = 3'd5
    } reg_addr_e;

    typedef struct packed {
        logic irq_sec_en;
        logic irq_alarm_en;
        logic alarm_en;
        logic run;
    } control_t;

    localparam logic [15:0] PRESC_LAST  = 16'(TICKS_PER_SEC - 1);
    localparam logic [5:0]  SNOOZE_INIT = 6'(SNOOZE_RESET);

    // Increment one BCD field. Returns {carry, value}. Anything at or above
    // max wraps to 0, which is how out-of-range written values self-correct.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [8:0] r;
        if (v >= max) begin
            r = {1'b1, 8'h00};
        end else if (v[3:0] >= 4'd9) begin
            r = {1'b0, v[7:4] + 4'd1, 4'h0};
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    control_t    control;
    logic [15:0] prescaler;
    logic [5:0]  hours;
    logic [6:0]  minutes;
    logic [6:0]  seconds;
    logic [5:0]  alarm_h;
    logic [6:0]  alarm_m;
    logic [5:0]  snooze_len;
    logic [5:0]  snooze_cnt;
    logic        alarm_flag;
    logic        sec_flag;
    logic        snooze_active;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic wr_en;
    logic status_wr, control_wr, time_hm_wr, time_s_wr, alarm_wr, snooze_wr;

    assign wr_en      = chipselect & ~write_n;
    assign status_wr  = wr_en & (address == ADDR_STATUS);
    assign control_wr = wr_en & (address == ADDR_CONTROL);
    assign time_hm_wr = wr_en & (address == ADDR_TIME_HM);
    assign time_s_wr  = wr_en & (address == ADDR_TIME_S);
    assign alarm_wr   = wr_en & (address == ADDR_ALARM_HM);
    assign snooze_wr  = wr_en & (address == ADDR_SNOOZE);

    // ------------------------------------------------------------------
    // Time advance and event detection
    // ------------------------------------------------------------------
    logic [8:0] sec_inc, min_inc, hr_inc;
    logic       tick_count;
    logic       sec_advance;
    logic       minute_event;
    logic [6:0] new_min;
    logic [5:0] new_hr;
    logic       alarm_match;
    logic       snooze_start;
    logic       snooze_expire;

    always_comb begin
        // NOTE: every signal driven here gets a value on every path (the
        // function calls and plain expressions below), so no latch can form.
        sec_inc = bcd_inc({1'b0, seconds}, 8'h59);
        min_inc = bcd_inc({1'b0, minutes}, 8'h59);
        hr_inc  = bcd_inc({2'b0, hours},   8'h23);

        tick_count = control.run & tick_in;
        // A time write in the same cycle discards the advance entirely.
        sec_advance  = tick_count & (prescaler == PRESC_LAST)
                       & ~time_hm_wr & ~time_s_wr;
        minute_event = sec_advance & sec_inc[8];

        new_min = min_inc[6:0];
        new_hr  = min_inc[8] ? hr_inc[5:0] : hours;

        alarm_match   = minute_event & control.alarm_en
                        & (new_hr == alarm_h) & (new_min == alarm_m);
        snooze_start  = status_wr & writedata[2] & alarm_flag;
        snooze_expire = minute_event & snooze_active & (snooze_cnt == 6'd1);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            control       <= '0;
            prescaler     <= '0;
            hours         <= '0;
            minutes       <= '0;
            seconds       <= '0;
            alarm_h       <= 6'h07;
            alarm_m       <= 7'h00;
            snooze_len    <= SNOOZE_INIT;
            snooze_cnt    <= '0;
            alarm_flag    <= 1'b0;
            sec_flag      <= 1'b0;
            snooze_active <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; several branches
            // below deliberately let a later assignment override an earlier
            // one in the same cycle (sets win over clears).

            if (control_wr) control <= control_t'(writedata[3:0]);
            if (alarm_wr) begin
                alarm_h <= writedata[13:8];
                alarm_m <= writedata[6:0];
            end
            if (snooze_wr) snooze_len <= writedata[5:0];

            // Prescaler: a time write restarts the current second.
            if (time_hm_wr || time_s_wr) begin
                prescaler <= '0;
            end else if (tick_count) begin
                prescaler <= (prescaler == PRESC_LAST) ? 16'd0 : prescaler + 16'd1;
            end

            // Time of day
            if (time_hm_wr) begin
                hours   <= writedata[13:8];
                minutes <= writedata[6:0];
                seconds <= '0;
            end else if (time_s_wr) begin
                seconds <= writedata[6:0];
            end else if (sec_advance) begin
                seconds <= sec_inc[6:0];
                if (minute_event) begin
                    minutes <= new_min;
                    hours   <= new_hr;
                end
            end

            // Flag clears first, then sets, so a coincident event is kept.
            if (status_wr && writedata[0]) alarm_flag <= 1'b0;
            if (status_wr && writedata[1]) sec_flag   <= 1'b0;
            if (sec_advance)               sec_flag   <= 1'b1;

            // Snooze start: park the alarm and arm the countdown.
            if (snooze_start) begin
                alarm_flag    <= 1'b0;
                snooze_active <= 1'b1;
                snooze_cnt    <= (snooze_len == 6'd0) ? 6'd1 : snooze_len;
            end else if (minute_event && snooze_active && snooze_cnt != 6'd0) begin
                snooze_cnt <= snooze_cnt - 6'd1;
            end

            if (control_wr && !writedata[1]) snooze_active <= 1'b0;

            if (snooze_expire) begin
                snooze_active <= 1'b0;
                if (control.alarm_en) alarm_flag <= 1'b1;
            end

            // A real match beats a snooze request in the same cycle.
            if (alarm_match) begin
                alarm_flag    <= 1'b1;
                snooze_active <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: registered every cycle regardless of chipselect
    // ------------------------------------------------------------------
    logic [15:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS:   rd_mux = {13'b0, snooze_active, sec_flag, alarm_flag};
            ADDR_CONTROL:  rd_mux = {12'b0, control};
            ADDR_TIME_HM:  rd_mux = {2'b0, hours, 1'b0, minutes};
            ADDR_TIME_S:   rd_mux = {9'b0, seconds};
            ADDR_ALARM_HM: rd_mux = {2'b0, alarm_h, 1'b0, alarm_m};
            ADDR_SNOOZE:   rd_mux = {10'b0, snooze_len};
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign irq = (alarm_flag & control.irq_alarm_en) | (sec_flag & control.irq_sec_en);
    assign alarm_active = alarm_flag;

    // Bits that carry no information in this design.
    logic unused_bits;
    assign unused_bits = ^{writedata[15:14], writedata[7],
                           sec_inc[7], min_inc[7], hr_inc[7:6]};

endmodule

// File: tb/tb_alarm_rtc_core.sv
// -----------------------------------------------------------------------------
// tb_alarm_rtc_core
//
// Directed bench for alarm_rtc_core with TICKS_PER_SEC = 4. Expected values
// are hand-computed and written inline at each step.
// -----------------------------------------------------------------------------
module tb_alarm_rtc_core;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        tick_in = 1'b0;
    logic        irq;
    logic        alarm_active;

    int n_checks = 0;
    int n_fail   = 0;

    alarm_rtc_core #(
        .TICKS_PER_SEC (4),
        .SNOOZE_RESET  (5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .tick_in      (tick_in),
        .irq          (irq),
        .alarm_active (alarm_active)
    );

    always #5 clk = ~clk;

    // Time limit: the whole run is a few thousand cycles.
    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_rd(a, d);
        check(tag, d, exp);
    endtask

    // One tick_in pulse per call iteration; returns 1 ns after the edge that
    // consumed the last pulse so outputs can be checked right away.
    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            tick_in = 1'b1;
            @(posedge clk);
            #1;
            tick_in = 1'b0;
        end
    endtask

    // A tick and a bus write landing on the same clock edge.
    task automatic tick_with_wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        tick_in    = 1'b1;
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        tick_in    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        logic [15:0] exp_defaults [8];
        exp_defaults = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                         16'h0700, 16'h0005, 16'h0000, 16'h0000};

        // ---------------- Reset state ----------------
        #12;
        check("reset_irq", {15'b0, irq}, 16'h0000);
        check("reset_alarm_active", {15'b0, alarm_active}, 16'h0000);
        check("reset_readdata", readdata, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_rd($sformatf("reset_rd_addr%0d", i), 3'(i), exp_defaults[i]);
        end

        // ---------------- Full-day rollover ----------------
        bus_wr(3'd2, 16'h2359);
        bus_wr(3'd3, 16'h0058);
        bus_wr(3'd1, 16'h0001);
        ticks(7);
        check_rd("pre_wrap_time_s", 3'd3, 16'h0059);
        check_rd("pre_wrap_time_hm", 3'd2, 16'h2359);
        ticks(1);
        check_rd("wrap_time_hm", 3'd2, 16'h0000);
        check_rd("wrap_time_s", 3'd3, 16'h0000);
        check_rd("wrap_status_sec", 3'd0, 16'h0002);

        // ---------------- Alarm match ----------------
        bus_wr(3'd0, 16'h0002);
        bus_wr(3'd4, 16'h0701);
        bus_wr(3'd2, 16'h0700);
        bus_wr(3'd1, 16'h0007);
        check_rd("tm_write_no_alarm", 3'd0, 16'h0000);
        ticks(239);
        check("alarm_irq_before", {15'b0, irq}, 16'h0000);
        ticks(1);
        check("alarm_irq_after", {15'b0, irq}, 16'h0001);
        check("alarm_active_after", {15'b0, alarm_active}, 16'h0001);
        check_rd("alarm_status", 3'd0, 16'h0003);
        check_rd("alarm_time_hm", 3'd2, 16'h0701);
        bus_wr(3'd0, 16'h0001);
        check("alarm_clr_irq", {15'b0, irq}, 16'h0000);
        check("alarm_clr_active", {15'b0, alarm_active}, 16'h0000);

        // ---------------- Snooze ----------------
        bus_wr(3'd4, 16'h0702);
        bus_wr(3'd5, 16'h0002);
        ticks(240);
        check_rd("snz_alarm_fired", 3'd0, 16'h0003);
        bus_wr(3'd0, 16'h0006);
        check_rd("snz_started", 3'd0, 16'h0004);
        check("snz_irq_low", {15'b0, irq}, 16'h0000);
        ticks(240);
        check_rd("snz_after_1min", 3'd0, 16'h0006);
        ticks(239);
        check("snz_irq_before_2min", {15'b0, irq}, 16'h0000);
        ticks(1);
        check("snz_irq_after_2min", {15'b0, irq}, 16'h0001);
        check_rd("snz_status_2min", 3'd0, 16'h0003);
        check_rd("snz_time_hm", 3'd2, 16'h0704);

        // ---------------- Invalid time self-corrects ----------------
        bus_wr(3'd0, 16'h0003);
        bus_wr(3'd1, 16'h0001);
        bus_wr(3'd2, 16'h2A75);
        check_rd("bad_tm_readback", 3'd2, 16'h2A75);
        check_rd("bad_tm_sec_cleared", 3'd3, 16'h0000);
        ticks(240);
        check_rd("bad_tm_wrapped", 3'd2, 16'h0000);
        check_rd("bad_tm_sec", 3'd3, 16'h0000);

        // ---------------- Simultaneous events ----------------
        bus_wr(3'd0, 16'h0002);
        check_rd("sim_sec_cleared", 3'd0, 16'h0000);
        ticks(3);
        tick_with_wr(3'd0, 16'h0002);
        check_rd("sim_set_wins", 3'd0, 16'h0002);
        check_rd("sim_sec_advanced", 3'd3, 16'h0001);
        ticks(3);
        tick_with_wr(3'd3, 16'h0030);
        check_rd("sim_write_wins", 3'd3, 16'h0030);
        ticks(3);
        check_rd("sim_presc_restart", 3'd3, 16'h0030);
        ticks(1);
        check_rd("sim_next_second", 3'd3, 16'h0031);

        // ---------------- Mid-count asynchronous reset ----------------
        bus_wr(3'd1, 16'h0009);
        check("pre_rst_irq_sec", {15'b0, irq}, 16'h0001);
        ticks(2);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_irq", {15'b0, irq}, 16'h0000);
        check("rst_async_readdata", readdata, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_rd($sformatf("post_rst_addr%0d", i), 3'(i), exp_defaults[i]);
        end
        ticks(4);
        check_rd("post_rst_held", 3'd3, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
